// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared definitions for the GPIO input path and the AHB GPIO peripheral.
//   GPIO_WIDTH    - number of GPIO data pins
//   GPIO_PAR_BIT  - index of the parity bit on the GPIOIN bus
//   gpioin_t      - GPIOIN bus layout {parity, data}
//   gpio_parity() - reduction parity of data XOR sense select
package gpio_pkg;

    localparam int GPIO_WIDTH   = 16;
    localparam int GPIO_PAR_BIT = 16;

    typedef struct packed {
        logic                  par;
        logic [GPIO_WIDTH-1:0] data;
    } gpioin_t;

    // sel = 0 gives even parity, sel = 1 gives odd parity.
    function automatic logic gpio_parity(input logic [GPIO_WIDTH-1:0] data,
                                         input logic                  sel);
        return (^data) ^ sel;
    endfunction

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// gpio_in_conditioner_if
// Pin-side and GPIOIN-side signals of the input conditioner.
//   PIN_IN      raw asynchronous pins
//   PARITYSEL   parity sense (0 even, 1 odd)
//   PAR_INJECT  inverts the generated parity bit
//   GPIOIN_OUT  {parity, debounced data}
//   CHG_PULSE   one-cycle pulse on any debounced change
//   CHG_MASK    bits that changed, zero when no pulse
// slave modport: the conditioner. master modport: whatever drives/consumes it.
interface gpio_in_conditioner_if;
    import gpio_pkg::*;

    logic [GPIO_WIDTH-1:0] PIN_IN;
    logic                  PARITYSEL;
    logic                  PAR_INJECT;
    logic [GPIO_WIDTH:0]   GPIOIN_OUT;
    logic                  CHG_PULSE;
    logic [GPIO_WIDTH-1:0] CHG_MASK;

    modport slave (
        input  PIN_IN, PARITYSEL, PAR_INJECT,
        output GPIOIN_OUT, CHG_PULSE, CHG_MASK
    );

    modport master (
        output PIN_IN, PARITYSEL, PAR_INJECT,
        input  GPIOIN_OUT, CHG_PULSE, CHG_MASK
    );

endinterface

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit
// Synchroniser, debounce counter and stable flop for a single pin.
//   HCLK, HRESETn  clock, async active-low reset
//   pin            raw asynchronous pin
//   s              debounced stable level (registered)
//   s_next         value s takes on the coming edge (for parity lookahead)
//   chg            registered one-cycle flag: s changed on the last edge
module gpio_debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic pin,
    output logic s,
    output logic s_next,
    output logic chg
);

    localparam int                CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]     LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   chg_nxt;

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // Counter only advances while the synchronised level disagrees with s;
    // any agreeing cycle clears it, so short glitches are dropped. The flip
    // happens at LAST, so cnt never goes past DEBOUNCE_CYCLES-1.
    always_comb begin
        s_next  = s;
        cnt_nxt = '0;
        chg_nxt = 1'b0;
        if (sync_q != s) begin
            if (cnt == LAST) begin
                s_next  = sync_q;
                chg_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_ff <= '0;
            cnt     <= '0;
            s       <= 1'b0;
            chg     <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], pin};
            cnt     <= cnt_nxt;
            s       <= s_next;
            chg     <= chg_nxt;
        end
    end

endmodule

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
// Synchronises and debounces 16 external pins, appends a registered parity
// bit and reports debounced level changes.
//   HCLK, HRESETn  clock, async active-low reset
//   bus (slave)    PIN_IN/PARITYSEL/PAR_INJECT in,
//                  GPIOIN_OUT/CHG_PULSE/CHG_MASK out
// Every output comes from flops (CHG_PULSE is an OR of chg flops only).
module gpio_in_conditioner
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    gpio_in_conditioner_if.slave  bus
);

    logic [GPIO_WIDTH-1:0] s, s_next, chg;
    logic                  p;

    for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_bit
        gpio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .pin     (bus.PIN_IN[gi]),
            .s       (s[gi]),
            .s_next  (s_next[gi]),
            .chg     (chg[gi])
        );
    end

    // Parity is computed from s_next so it lands on the same edge as the
    // data, never showing a stale-data/new-sel mix.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) p <= 1'b0;
        else          p <= gpio_parity(s_next, bus.PARITYSEL) ^ bus.PAR_INJECT;
    end

    assign bus.GPIOIN_OUT = gpioin_t'{par: p, data: s};
    assign bus.CHG_MASK   = chg;
    assign bus.CHG_PULSE  = |chg;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
module tb_gpio_in_conditioner;
    import gpio_pkg::*;

    logic HCLK = 1'b0;
    logic HRESETn;
    int   n_cmp  = 0;
    int   n_fail = 0;

    gpio_in_conditioner_if bus ();

    gpio_in_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    // Advance to 1ns after the next rising edge; inputs change and outputs
    // are sampled there.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic chk17(input string name, input logic [16:0] got, input logic [16:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        HRESETn        = 1'b0;
        bus.PIN_IN     = 16'hFFFF;
        bus.PARITYSEL  = 1'b0;
        bus.PAR_INJECT = 1'b0;
        tick(3);
        chk17("reset_gpioin", bus.GPIOIN_OUT, 17'h0);
        chk16("reset_pulse", {15'd0, bus.CHG_PULSE}, 16'h0);
        chk16("reset_mask", bus.CHG_MASK, 16'h0);
        HRESETn = 1'b1;
        tick(5);
        chk17("reset_e4_unchanged", bus.GPIOIN_OUT, 17'h0);
        tick(1);
        chk17("reset_e5_gpioin", bus.GPIOIN_OUT, 17'h0FFFF);
        chk16("reset_e5_mask", bus.CHG_MASK, 16'hFFFF);
        chk16("reset_e5_pulse", {15'd0, bus.CHG_PULSE}, 16'h1);
        tick(1);
        chk16("reset_e6_mask", bus.CHG_MASK, 16'h0);
        chk16("reset_e6_pulse", {15'd0, bus.CHG_PULSE}, 16'h0);
    endtask

    task automatic test_single_flip;
        bus.PIN_IN = 16'h0000;
        tick(8);
        chk17("flip_settle0", bus.GPIOIN_OUT, 17'h0);
        bus.PIN_IN = 16'h0001;
        tick(5);
        chk17("flip_e4", bus.GPIOIN_OUT, 17'h0);
        chk16("flip_e4_pulse", {15'd0, bus.CHG_PULSE}, 16'h0);
        tick(1);
        chk17("flip_e5", bus.GPIOIN_OUT, 17'h10001);
        chk16("flip_e5_mask", bus.CHG_MASK, 16'h0001);
        tick(1);
        chk16("flip_e6_mask", bus.CHG_MASK, 16'h0);
    endtask

    task automatic test_glitch;
        int pulses;
        logic [15:0] seen;
        pulses = 0;
        seen   = '0;
        // 3-cycle high pulse on bit 3: must be discarded.
        bus.PIN_IN = 16'h0009;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (bus.CHG_PULSE) pulses++;
        end
        bus.PIN_IN = 16'h0001;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (bus.CHG_PULSE) pulses++;
        end
        chk16("glitch3_pulses", 16'(pulses), 16'd0);
        chk17("glitch3_gpioin", bus.GPIOIN_OUT, 17'h10001);
        // 4-cycle pulse survives; bit 3 rises at E5 and falls 4 edges later.
        pulses     = 0;
        bus.PIN_IN = 16'h0009;
        tick(4);
        bus.PIN_IN = 16'h0001;
        tick(2);
        chk17("glitch4_rise", bus.GPIOIN_OUT, 17'h00009);
        chk16("glitch4_mask", bus.CHG_MASK, 16'h0008);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (bus.CHG_PULSE) begin
                pulses++;
                seen = bus.CHG_MASK;
            end
        end
        chk16("glitch4_fall_pulses", 16'(pulses), 16'd1);
        chk16("glitch4_fall_mask", seen, 16'h0008);
        chk17("glitch4_final", bus.GPIOIN_OUT, 17'h10001);
    endtask

    task automatic test_parity_inject;
        bus.PIN_IN = 16'h0003;
        tick(8);
        chk17("par_even", bus.GPIOIN_OUT, 17'h00003);
        bus.PARITYSEL = 1'b1;
        tick(1);
        chk17("par_odd", bus.GPIOIN_OUT, 17'h10003);
        chk16("par_odd_pulse", {15'd0, bus.CHG_PULSE}, 16'h0);
        bus.PAR_INJECT = 1'b1;
        tick(1);
        chk17("par_inject", bus.GPIOIN_OUT, 17'h00003);
        chk16("par_inject_pulse", {15'd0, bus.CHG_PULSE}, 16'h0);
        bus.PARITYSEL  = 1'b0;
        bus.PAR_INJECT = 1'b0;
        tick(1);
        chk17("par_restore", bus.GPIOIN_OUT, 17'h00003);
    endtask

    task automatic test_multi_bit;
        int pulses;
        logic [15:0] seen;
        pulses = 0;
        seen   = '0;
        bus.PIN_IN = 16'h0000;
        tick(8);
        bus.PIN_IN = 16'hA5A5;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.CHG_PULSE) begin
                pulses++;
                seen = bus.CHG_MASK;
            end
        end
        chk16("multi_pulses", 16'(pulses), 16'd1);
        chk16("multi_mask", seen, 16'hA5A5);
        chk17("multi_gpioin", bus.GPIOIN_OUT, 17'h0A5A5);
    endtask

    task automatic test_reset_mid_count;
        bus.PIN_IN = 16'hA525;
        tick(2);
        HRESETn = 1'b0;
        #1;
        chk17("rmid_gpioin", bus.GPIOIN_OUT, 17'h0);
        chk16("rmid_mask", bus.CHG_MASK, 16'h0);
        tick(2);
        HRESETn = 1'b1;
        tick(5);
        chk17("rmid_e4", bus.GPIOIN_OUT, 17'h0);
        tick(1);
        chk17("rmid_e5", bus.GPIOIN_OUT, 17'h1A525);
        chk16("rmid_e5_mask", bus.CHG_MASK, 16'hA525);
        tick(3);
    endtask

    task automatic test_flip_with_paritysel;
        // s goes A525 -> A5A5 (even count) on the same edge PARITYSEL rises.
        bus.PIN_IN = 16'hA5A5;
        tick(5);
        chk17("fsel_e4", bus.GPIOIN_OUT, 17'h1A525);
        bus.PARITYSEL = 1'b1;
        tick(1);
        chk17("fsel_e5", bus.GPIOIN_OUT, 17'h1A5A5);
        chk16("fsel_mask", bus.CHG_MASK, 16'h0080);
    endtask

    initial begin
        test_reset();
        test_single_flip();
        test_glitch();
        test_parity_inject();
        test_multi_bit();
        test_reset_mid_count();
        test_flip_with_paritysel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_in_conditioner.md
# gpio_in_conditioner

Input conditioning stage placed directly upstream of the AHB GPIO peripheral. It takes 16 asynchronous external pins, synchronises and debounces each bit independently, and appends a registered parity bit. The result drives the peripheral's 17-bit GPIOIN bus: data on [15:0], parity on [16]. It also flags every debounced level change with a single-cycle pulse.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth per pin; legal range is 2 or more.
- DEBOUNCE_CYCLES, 4, consecutive mismatching cycles needed before a bit flips; legal range is 1 or more (1 means no filtering).

Ports:
- HCLK  input  1  clock.
- HRESETn  input  1  reset; asynchronous, active-low.
- PIN_IN  input  16  raw external pins, asynchronous to HCLK.
- PARITYSEL  input  1  parity sense: 0 selects even, 1 selects odd.
- PAR_INJECT  input  1  error injection for test; inverts the generated parity bit.
- GPIOIN_OUT  output  17  {parity, debounced data}; connects to the peripheral's GPIOIN.
- CHG_PULSE  output  1  high for one cycle after any debounced bit changes.
- CHG_MASK  output  16  bits that changed on that edge; valid while CHG_PULSE is high, zero otherwise.

## Operation
- Synchroniser: each PIN_IN bit passes through SYNC_STAGES flops. sync_q is the last stage.
- Per-bit debounce state: stable bit s[i] and counter cnt[i], of width $clog2(DEBOUNCE_CYCLES+1).
  - sync_q[i] == s[i]: cnt[i] <= 0.
  - sync_q[i] != s[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync_q[i] != s[i] and cnt[i] == DEBOUNCE_CYCLES-1: s[i] <= sync_q[i], cnt[i] <= 0, chg[i] <= 1.
  - chg[i] <= 0 in every other case.
- Bits are fully independent. Several bits may flip on the same edge; CHG_MASK then has several ones and CHG_PULSE is a single pulse.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles is discarded: the counter clears and s is unchanged.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Parity register p:
  - p <= (^s_next) ^ PARITYSEL ^ PAR_INJECT every cycle, where s_next is the value s takes on the same edge.
  - With PAR_INJECT=0, ^{p, s} == PARITYSEL always holds after the first post-reset edge.
- GPIOIN_OUT = {p, s}. CHG_MASK = chg. CHG_PULSE = |chg. All outputs come directly from flops, with no combinational path from inputs.

## Timing
- Reset (asynchronous assert, synchronous release by the system):
  - sync flops, s, cnt, chg, p all 0.
  - GPIOIN_OUT = 17'h0, CHG_PULSE = 0, CHG_MASK = 16'h0.
- First edge after release:
  - p loads (^s) ^ PARITYSEL ^ PAR_INJECT, so with PARITYSEL=1 bit 16 reads 0 for exactly one cycle.
  - Pins held high through reset begin debouncing normally. No bypass.
- Let E0 be the first edge sampling a new, steady level on a pin:
  - sync_q changes at E(SYNC_STAGES-1).
  - s and the parity bit change at E(SYNC_STAGES+DEBOUNCE_CYCLES-1).
  - With defaults: at E5, i.e. 6 edges including E0.
- CHG_PULSE/CHG_MASK go high on the same edge as s changes and drop on the next edge, unless another bit flips on that edge.
- PARITYSEL or PAR_INJECT change: reflected in GPIOIN_OUT[16] after one edge. Data bits are unaffected and CHG_PULSE does not fire.
- Pin returns to the old level mid-count: cnt clears on the first matching sync_q cycle, and a later mismatch restarts from 0.
- Reset asserted mid-count: all state clears immediately, and any pending change is lost.
- Simultaneous flip and PARITYSEL change on one edge: p uses the new s and the current PARITYSEL. No intermediate value appears.

## Structure
- Shared package gpio_pkg:
  - GPIO_WIDTH = 16 and GPIO_PAR_BIT = 16, also used by the GPIO peripheral.
  - gpio_parity(data, sel) function returning (^data) ^ sel.
- Sub-module gpio_debounce_bit (parameters SYNC_STAGES, DEBOUNCE_CYCLES):
  - Contains the synchroniser, counter and stable flop for one pin.
  - Outputs s, s_next and chg.
  - Instantiated GPIO_WIDTH times in a generate loop.
- Top level holds only the parity flop and the CHG_PULSE/CHG_MASK reduction.

## Test plan
- Reset: hold HRESETn low with PIN_IN=16'hFFFF -> GPIOIN_OUT=17'h0 and CHG_PULSE=0. After release, with defaults, GPIOIN_OUT becomes 17'h0FFFF at the 6th edge (even parity of 16 ones = 0). CHG_MASK=16'hFFFF for one cycle.
- Single flip: PIN_IN 16'h0000 -> 16'h0001, PARITYSEL=0 -> GPIOIN_OUT=17'h10001 exactly 6 edges after the first sampling edge. CHG_MASK=16'h0001 for 1 cycle.
- Glitch rejection: pulse PIN_IN[3] high for 3 cycles, then low -> GPIOIN_OUT unchanged and CHG_PULSE never asserts. A 4-cycle pulse produces a change.
- Odd parity and inject: data 16'h0003, toggle PARITYSEL 0->1 -> bit 16 goes 0->1 after one edge. Then assert PAR_INJECT -> bit 16 goes back to 0 after one edge. No CHG_PULSE throughout.
- Multi-bit: PIN_IN 16'h0000 -> 16'hA5A5 in one cycle -> a single CHG_PULSE with CHG_MASK=16'hA5A5, and GPIOIN_OUT=17'h0A5A5.
- Reset mid-count: change PIN_IN[7], then assert HRESETn 2 cycles later -> all outputs 0 immediately. After release, a fresh full 6-edge latency applies.
